colour_sensor_scanner: RTL
==========================

# colour_sensor_scanner

Parametrised scan controller for the TCS3200-class colour sensor on the soil-monitoring bot. It steps the sensor's photodiode filter through red, green and blue, plus clear when configured. For each channel it counts output-frequency edges over a fixed gate window, then classifies the dominant colour and drives the RGB indicator LEDs. It sits between the sensor pins and the bot's reporting logic and supports single-shot and continuous scanning.

## Interface
- GATE_CYCLES, 100000: clk cycles per channel measurement window (≥1)
- SETTLE_CYCLES, 1000: clk cycles after a filter change before counting starts (≥1)
- CNT_W, 16: width of each per-channel edge counter
- SCALE, 2'b01: {S1,S0} output-frequency scaling while scanning (01 = 20 %)
- MIN_COUNT, 16: below this count the result is "no colour"
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; low aborts any scan
- start  in  1  single-cycle request for one scan, sampled in IDLE
- cont  in  1  continuous mode: rescan immediately after each decision
- freq  in  1  sensor square-wave output, asynchronous
- s  out  4  sensor select pins {S3,S2,S1,S0}
- ch_count  out  4*CNT_W  latched counts, slots [0]=red [1]=green [2]=blue [3]=clear
- colour  out  2  00 red, 01 green, 10 blue, 11 none
- led  out  3  one-hot RGB: 100 red, 010 green, 001 blue, 000 none
- valid  out  1  one-cycle pulse when colour/led/ch_count update
- busy  out  1  high in any state except IDLE

## Operation
- The FSM has five states:
  - IDLE
  - SETTLE: lasts SETTLE_CYCLES cycles
  - GATE: lasts GATE_CYCLES cycles
  - NEXT: merged into the GATE exit, no extra cycle
  - DECIDE: 1 cycle
- IDLE→SETTLE(ch0) when en && (start || cont).
- SETTLE→GATE after SETTLE_CYCLES.
- GATE→SETTLE(ch+1) after GATE_CYCLES. The last channel's GATE goes to DECIDE instead.
- DECIDE→SETTLE(ch0) if en && cont; otherwise DECIDE→IDLE.
- The scan order is red, green, blue, then clear.
- Filter codes {S3,S2} are: red 00, green 11, blue 10, clear 01.
- During a scan, s = {filter, SCALE}. For example, red scanned at 20 % gives 0001, green gives 1101, blue gives 1001.
- In IDLE, s = 4'b0000 (sensor powered down).
- freq passes through a 2-flop synchroniser, then a rising-edge detector. Edges are counted only in GATE.
- The counter clears on GATE entry and saturates at all-ones, never wrapping.
- On the final GATE cycle, the count is latched into the channel's ch_count slot. That final cycle's edge is included.
- DECIDE compares the red, green and blue counts:
  - argmax wins.
  - On a tie, the lower index wins (red > green > blue).
  - If the winning count < MIN_COUNT, the result is colour = 11 and led = 000.
- colour, led and valid are registered at the end of DECIDE.
- en low in any non-IDLE state moves to IDLE next cycle:
  - no valid is issued
  - colour, led and ch_count keep their previous values
  - a partially latched ch_count slot from the aborted scan is permitted
- start while busy is ignored.
- Reset values:
  - s = 0000
  - ch_count = 0
  - colour = 11
  - led = 000
  - valid = 0
  - busy = 0
  - FSM in IDLE
- rst mid-scan produces these reset values on the next cycle.

## Timing
- Let NCH = 3, or 4 with the clear channel.
- start high in cycle 0: SETTLE begins in cycle 1, DECIDE is in cycle NCH*(S+G)+1, and valid is high in cycle NCH*(S+G)+2. Here S = SETTLE_CYCLES and G = GATE_CYCLES.
- Continuous mode: consecutive valid pulses are exactly NCH*(S+G)+1 cycles apart.
- A freq edge at the pin is counted 3 clk later. Edges within 3 cycles of GATE entry or exit may fall either side, so the tolerance is ±1 count.
- freq must satisfy high and low times ≥ 2 clk periods.

## Configuration
- COLOUR_SCAN_CLEAR_EN defined:
  - NCH = 4, with the clear channel scanned after blue into slot [3].
  - The "none" test uses the clear count: if clear < MIN_COUNT, the result is none, regardless of RGB.
- COLOUR_SCAN_CLEAR_EN not defined:
  - NCH = 3 and slot [3] stays 0.
  - "none" is decided by the winning RGB count < MIN_COUNT.

## Structure
- colour_sensor_pkg holds:
  - the colour encodings (red, green, blue, none)
  - the filter codes per channel
  - the FSM state enum
  - the channel index constants
- Sub-module freq_edge_counter contains the synchroniser, edge detect, and the saturating CNT_W counter with clear/enable.

## Test plan
- Single-shot scan, S=4, G=1000. Stimulus: red edge every 10 clk, green every 20, blue every 40. Expect ch_count ≈ 100/50/25 (±1), colour 00, led 100, and one valid in cycle 3014.
- Red and green both give edges every 20 clk, blue every 40. Expect colour 00 (tie goes to red).
- freq held low. Expect counts 0, colour 11, led 000, valid still pulses.
- CNT_W=4, freq period 4 clk, G=100. Expect every slot = 15 (saturated, no wrap).
- cont=1: valid pulses are spaced exactly 3*(S+G)+1 cycles apart. Dropping en during green GATE gives s=0000 next cycle, busy low, no valid, and prior results held.
- rst asserted mid-blue SETTLE. The next cycle shows all reset values, and start then runs a full clean scan.

Source files
------------

// File: rtl/colour_sensor_scanner_pkg.sv
// Shared encodings for the colour sensor scanner: colours, LEDs, filters, FSM states, channel indices.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package colour_sensor_pkg;

    // Colour result encodings
    localparam logic [1:0] COL_RED   = 2'b00;
    localparam logic [1:0] COL_GREEN = 2'b01;
    localparam logic [1:0] COL_BLUE  = 2'b10;
    localparam logic [1:0] COL_NONE  = 2'b11;

    // One-hot RGB indicator encodings
    localparam logic [2:0] LED_RED   = 3'b100;
    localparam logic [2:0] LED_GREEN = 3'b010;
    localparam logic [2:0] LED_BLUE  = 3'b001;
    localparam logic [2:0] LED_OFF   = 3'b000;

    // Channel indices, in scan order; also the ch_count slot numbers
    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
    localparam logic [1:0] CH_CLEAR = 2'd3;

    // Photodiode filter select codes {S3,S2}
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b10;
    localparam logic [1:0] FILT_CLEAR = 2'b01;

    // Scan FSM states. Channel advance (NEXT) is folded into the GATE exit,
    // so it never occupies a cycle of its own and has no encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // Filter code for a channel index
    function automatic logic [1:0] filter_code(input logic [1:0] ch);
        logic [1:0] f;
        case (ch)
            CH_RED:   f = FILT_RED;
            CH_GREEN: f = FILT_GREEN;
            CH_BLUE:  f = FILT_BLUE;
            default:  f = FILT_CLEAR;
        endcase
        return f;
    endfunction

    // Indicator pattern for a colour result
    function automatic logic [2:0] led_of(input logic [1:0] col);
        logic [2:0] l;
        case (col)
            COL_RED:   l = LED_RED;
            COL_GREEN: l = LED_GREEN;
            COL_BLUE:  l = LED_BLUE;
            default:   l = LED_OFF;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/colour_sensor_scanner_freq_edge_counter.sv
// Synchronises the async sensor square wave, detects rising edges, counts them saturating at all-ones.
// Latency: a pin edge reaches cnt_next three clk later (2-flop sync + edge register).
// Backpressure: none; the count is held whenever en is low, clr has priority over en.
module freq_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freq,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_next
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise;
    logic [CNT_W-1:0] cnt_inc;

    // Synchroniser, edge detect and saturating count update
    always_comb begin
        sync1_d = freq;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        cnt_inc = (rise && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
        cnt_next = cnt_inc;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/colour_sensor_scanner.sv
// Steps the TCS3200 filter through R,G,B (+clear with COLOUR_SCAN_CLEAR_EN), counts edges per gate, classifies colour.
// Latency: start in cycle 0 gives valid in cycle NCH*(SETTLE_CYCLES+GATE_CYCLES)+2.
// Backpressure: none; start while busy is ignored, en low aborts to IDLE with results held.
module colour_sensor_scanner
    import colour_sensor_pkg::*;
#(
    parameter int          GATE_CYCLES   = 100000,
    parameter int          SETTLE_CYCLES = 1000,
    parameter int          CNT_W         = 16,
    parameter logic [1:0]  SCALE         = 2'b01,
    parameter int unsigned MIN_COUNT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               cont,
    input  logic               freq,
    output logic [3:0]         s,
    output logic [4*CNT_W-1:0] ch_count,
    output logic [1:0]         colour,
    output logic [2:0]         led,
    output logic               valid,
    output logic               busy
);

`ifdef COLOUR_SCAN_CLEAR_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 3;
`endif
    localparam logic [1:0] LAST_CH = 2'(NCH - 1);
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] slot_q [4];
    logic [CNT_W-1:0] slot_d [4];
    logic [1:0]       colour_q, colour_d;
    logic [2:0]       led_q, led_d;
    logic             valid_q, valid_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_next;

    logic [1:0]       win_col;
    logic [CNT_W-1:0] win_cnt;
    logic             no_colour;
    logic [1:0]       dec_col;

    freq_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .freq     (freq),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt_next (cnt_next)
    );

    // Classification: argmax of R,G,B with ties to the lower index, then the "none" threshold
    always_comb begin
        win_col = COL_RED;
        win_cnt = slot_q[CH_RED];
        if (slot_q[CH_GREEN] > win_cnt) begin
            win_col = COL_GREEN;
            win_cnt = slot_q[CH_GREEN];
        end
        if (slot_q[CH_BLUE] > win_cnt) begin
            win_col = COL_BLUE;
            win_cnt = slot_q[CH_BLUE];
        end
`ifdef COLOUR_SCAN_CLEAR_EN
        // Overall brightness from the unfiltered channel decides "no colour"
        no_colour = (32'(slot_q[CH_CLEAR]) < MIN_COUNT);
`else
        no_colour = (32'(win_cnt) < MIN_COUNT);
`endif
        dec_col = no_colour ? COL_NONE : win_col;
    end

    // Scan FSM: next state, timers, slot latching and result update
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tmr_d    = tmr_q;
        slot_d   = slot_q;
        colour_d = colour_q;
        led_d    = led_q;
        valid_d  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        if ((state_q != ST_IDLE) && !en) begin
            // Abort: drop to IDLE, keep previously published results
            state_d = ST_IDLE;
            ch_d    = CH_RED;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && (start || cont)) begin
                        state_d = ST_SETTLE;
                        ch_d    = CH_RED;
                        tmr_d   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        state_d = ST_GATE;
                        tmr_d   = '0;
                        cnt_clr = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    cnt_en = 1'b1;
                    if (tmr_q == GATE_LAST) begin
                        // Latch including this cycle's edge; channel advance happens here
                        slot_d[ch_q] = cnt_next;
                        tmr_d        = '0;
                        if (ch_q == LAST_CH) begin
                            state_d = ST_DECIDE;
                        end else begin
                            state_d = ST_SETTLE;
                            ch_d    = ch_q + 2'd1;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_DECIDE: begin
                    valid_d  = 1'b1;
                    colour_d = dec_col;
                    led_d    = led_of(dec_col);
                    ch_d     = CH_RED;
                    tmr_d    = '0;
                    state_d  = cont ? ST_SETTLE : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= CH_RED;
            tmr_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            colour_q <= COL_NONE;
            led_q    <= LED_OFF;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            tmr_q    <= tmr_d;
            slot_q   <= slot_d;
            colour_q <= colour_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
        end
    end

    // Sensor pins and output packing
    always_comb begin
        s = (state_q == ST_IDLE) ? 4'b0000 : {filter_code(ch_q), SCALE};
        for (int i = 0; i < 4; i++) begin
            ch_count[i*CNT_W +: CNT_W] = slot_q[i];
        end
        colour = colour_q;
        led    = led_q;
        valid  = valid_q;
        busy   = (state_q != ST_IDLE);
    end

endmodule
